// File: rtl/vga_blob_frame_responder_pkg.sv
// Shared types and geometry helpers for the blob frame responder and its sync-side peers.
// Combinational only; no clocked logic lives here.
package vga_blob_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;

    function automatic int pix_per_frame(input int h_active, input int v_active);
        return h_active * v_active;
    endfunction

endpackage

// File: rtl/vga_blob_frame_responder_if.sv
// Capture-request, pixel stream and frame-buffer write bundle of the blob frame responder.
// master = upstream/sync side driving the inputs; slave = the responder.
interface vga_blob_frame_responder_if #(
    parameter int ADDR_W = 19
);
    logic              i_grayscale_start;
    logic              i_VGA_VSYNC;
    logic              i_pix_valid;
    logic [7:0]        i_pix_gray;
    logic              o_wr_en;
    logic [ADDR_W-1:0] o_wr_addr;
    logic [7:0]        o_wr_data;
    logic              o_blob_end;
    logic              o_busy;
    logic [3:0]        o_frame_cnt;
    logic              o_err_frame;

    modport master (
        output i_grayscale_start, i_VGA_VSYNC, i_pix_valid, i_pix_gray,
        input  o_wr_en, o_wr_addr, o_wr_data, o_blob_end, o_busy, o_frame_cnt, o_err_frame
    );

    modport slave (
        input  i_grayscale_start, i_VGA_VSYNC, i_pix_valid, i_pix_gray,
        output o_wr_en, o_wr_addr, o_wr_data, o_blob_end, o_busy, o_frame_cnt, o_err_frame
    );
endinterface

// File: rtl/vga_blob_frame_responder_vsync_edge.sv
// Rising-edge detector: one register of history, pulse is combinational in the edge cycle.
// No backpressure; the pulse is valid only in the cycle the input first reads high.
module vga_vsync_edge (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o
);
    logic sig_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~sig_q;
endmodule

// File: rtl/vga_blob_frame_responder.sv
// Captures FRAMES VSYNC-delimited grayscale frames into the blob buffer, then pulses o_blob_end.
// Pixel-to-write latency is 1 cycle; no backpressure, so pixels past a full frame are dropped and flagged.
module vga_blob_frame_responder
    import vga_blob_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int ADDR_W   = 19,
    parameter int FRAMES   = 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    vga_blob_frame_responder_if.slave     bus
);
    localparam int              PPF      = pix_per_frame(H_ACTIVE, V_ACTIVE);
    localparam int              CNT_W    = ADDR_W + 1;
    localparam logic [CNT_W-1:0] PPF_C   = CNT_W'(PPF);
    localparam logic [3:0]      FRAMES_C = 4'(FRAMES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [7:0]         wr_data_q, wr_data_d;
    logic               blob_end_q, blob_end_d;
    logic               busy_q, busy_d;
    logic [3:0]         frame_cnt_q, frame_cnt_d;
    logic               err_q, err_d;
    logic [3:0]         fc_inc;
    logic               vs_rise;

    vga_vsync_edge u_vs_edge (
        .clk_i  (i_clk),
        .rst_i  (i_rst),
        .sig_i  (bus.i_VGA_VSYNC),
        .rise_o (vs_rise)
    );

    assign fc_inc = frame_cnt_q + 4'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_cnt_d = frame_cnt_q;
        err_d       = err_q;

        case (state_q)
            IDLE: begin
                if (bus.i_grayscale_start) begin
                    state_d     = ARM;
                    frame_cnt_d = 4'd0;
                    err_d       = 1'b0;
                end
            end
            ARM: begin
                if (!bus.i_grayscale_start) begin
                    state_d = IDLE;
                end else if (vs_rise) begin
                    state_d = CAPTURE;
                    cnt_d   = '0;
                end
            end
            CAPTURE: begin
                if (!bus.i_grayscale_start) begin
                    state_d = IDLE;
                end else if (vs_rise) begin
                    // Boundary check sees the count before any coincident pixel lands.
                    if (cnt_q != PPF_C) begin
                        err_d = 1'b1;
                    end
                    frame_cnt_d = fc_inc;
                    if (fc_inc == FRAMES_C) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = '0;
                        if (bus.i_pix_valid) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = '0;
                            wr_data_d = bus.i_pix_gray;
                            cnt_d     = CNT_W'(1);
                        end
                    end
                end else if (bus.i_pix_valid) begin
                    if (cnt_q == PPF_C) begin
                        err_d = 1'b1;
                    end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = cnt_q[ADDR_W-1:0];
                        wr_data_d = bus.i_pix_gray;
                        cnt_d     = cnt_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                if (!bus.i_grayscale_start) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d     = (state_d != IDLE);
        blob_end_d = (state_d == DONE) && (state_q != DONE);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            blob_end_q  <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= 4'd0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            blob_end_q  <= blob_end_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
            err_q       <= err_d;
        end
    end

    assign bus.o_wr_en     = wr_en_q;
    assign bus.o_wr_addr   = wr_addr_q;
    assign bus.o_wr_data   = wr_data_q;
    assign bus.o_blob_end  = blob_end_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_frame_cnt = frame_cnt_q;
    assign bus.o_err_frame = err_q;
endmodule
